// File: rtl/unidade_funcional_cdb.sv
// Tomasulo execution unit: takes one issued op from a reservation station, runs it
// for a per-opcode latency, then requests the CDB and holds the result until granted.
module unidade_funcional_cdb #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int OPC_W   = 4,
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OPC_W-1:0]  issue_op,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic              flush,
    output logic              busy,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_err
);
    localparam int LAT_MAX = (LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD;
    localparam int CNT_W   = $clog2(LAT_MAX) + 1;

    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(4);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state, state_nxt;
    logic [OPC_W-1:0]  op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [CNT_W-1:0]  counter;
    logic              accept;
    int                lat_sel;
    logic [DATA_W:0]   res_issue, res_held;

    // {err, data}; unsupported opcodes yield zero data with the error flag set
    function automatic logic [DATA_W:0] alu(input logic [OPC_W-1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        logic              e;
        r = '0;
        e = 1'b0;
        case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_AND:  r = b & a;
            OP_OR:   r = b | a;
            OP_MUL:  r = b * a;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    assign issue_ready = (state == IDLE) && !flush;
    assign accept      = issue_valid && issue_ready;
    assign busy        = (state != IDLE);
    assign cdb_req     = (state == DONE);
    assign res_issue   = alu(issue_op, issue_a, issue_b);
    assign res_held    = alu(op_q, a_q, b_q);

    always_comb begin
        lat_sel = 1;
        if (issue_op == OP_MUL)
            lat_sel = LAT_MUL;
        else if (issue_op == OP_ADD || issue_op == OP_SUB ||
                 issue_op == OP_AND || issue_op == OP_OR)
            lat_sel = LAT_ADD;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Leaving EXEC on the edge that brings the counter to zero keeps the
    // request visible LAT-1 edges after the accept edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (lat_sel == 1) ? DONE : EXEC;
            EXEC:    if (counter <= CNT_W'(1)) state_nxt = DONE;
            DONE:    if (cdb_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            tag_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            counter  <= '0;
            cdb_tag  <= '0;
            cdb_data <= '0;
            cdb_err  <= 1'b0;
        end else if (flush) begin
            counter <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q    <= issue_op;
                    tag_q   <= issue_tag;
                    a_q     <= issue_a;
                    b_q     <= issue_b;
                    counter <= CNT_W'(lat_sel - 1);
                    if (lat_sel == 1) begin
                        cdb_tag  <= issue_tag;
                        cdb_data <= res_issue[DATA_W-1:0];
                        cdb_err  <= res_issue[DATA_W];
                    end
                end
                EXEC: if (counter <= CNT_W'(1)) begin
                    counter  <= '0;
                    cdb_tag  <= tag_q;
                    cdb_data <= res_held[DATA_W-1:0];
                    cdb_err  <= res_held[DATA_W];
                end else begin
                    counter <= counter - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_funcional_cdb.sv
// Directed bench for unidade_funcional_cdb: default instance plus a wide,
// slow-multiplier instance.
module tb_unidade_funcional_cdb;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // default-parameter instance
    logic        issue_valid, issue_ready, flush, busy, cdb_req, cdb_grant, cdb_err;
    logic [3:0]  issue_op;
    logic [2:0]  issue_tag, cdb_tag;
    logic [15:0] issue_a, issue_b, cdb_data;

    // DATA_W=32, LAT_MUL=4 instance
    logic        w_valid, w_ready, w_flush, w_busy, w_req, w_grant, w_err;
    logic [3:0]  w_op;
    logic [2:0]  w_tag, w_cdb_tag;
    logic [31:0] w_a, w_b, w_data;

    int checks   = 0;
    int failures = 0;

    unidade_funcional_cdb dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_tag(issue_tag), .issue_a(issue_a), .issue_b(issue_b), .flush(flush),
        .busy(busy), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_err(cdb_err)
    );

    unidade_funcional_cdb #(.DATA_W(32), .LAT_MUL(4)) dut_w (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(w_valid), .issue_ready(w_ready), .issue_op(w_op),
        .issue_tag(w_tag), .issue_a(w_a), .issue_b(w_b), .flush(w_flush),
        .busy(w_busy), .cdb_req(w_req), .cdb_grant(w_grant), .cdb_tag(w_cdb_tag),
        .cdb_data(w_data), .cdb_err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] tg,
                         input logic [15:0] a, input logic [15:0] b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_tag   = tg;
        issue_a     = a;
        issue_b     = b;
    endtask

    initial begin
        reset_n = 1'b0;
        issue_valid = 0; issue_op = 0; issue_tag = 0; issue_a = 0; issue_b = 0;
        flush = 0; cdb_grant = 0;
        w_valid = 0; w_op = 0; w_tag = 0; w_a = 0; w_b = 0; w_flush = 0; w_grant = 0;
        #2;
        check("rst_req",  {31'd0, cdb_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tag",  {29'd0, cdb_tag}, 32'd0);
        check("rst_data", {16'd0, cdb_data}, 32'd0);
        check("rst_err",  {31'd0, cdb_err}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, issue_ready}, 32'd1);
        step;

        // ADD, grant tied high
        issue(4'h0, 3'd2, 16'd3, 16'd5);
        cdb_grant = 1'b1;
        step;
        issue_valid = 1'b0;
        check("add_req",  {31'd0, cdb_req}, 32'd1);
        check("add_data", {16'd0, cdb_data}, 32'd8);
        check("add_tag",  {29'd0, cdb_tag}, 32'd2);
        check("add_err",  {31'd0, cdb_err}, 32'd0);
        check("add_ready_done", {31'd0, issue_ready}, 32'd0);
        step;
        check("add_req_gone", {31'd0, cdb_req}, 32'd0);
        check("add_ready_back", {31'd0, issue_ready}, 32'd1);

        // SUB wrap, then hold without grant while another issue is offered
        cdb_grant = 1'b0;
        issue(4'h1, 3'd1, 16'd5, 16'd3);
        step;
        issue(4'h0, 3'd7, 16'd1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_req",   {31'd0, cdb_req}, 32'd1);
            check("hold_data",  {16'd0, cdb_data}, 32'h0000_FFFE);
            check("hold_tag",   {29'd0, cdb_tag}, 32'd1);
            check("hold_ready", {31'd0, issue_ready}, 32'd0);
            step;
        end
        issue_valid = 1'b0;
        cdb_grant = 1'b1;
        step;
        check("hold_release_req",   {31'd0, cdb_req}, 32'd0);
        check("hold_release_ready", {31'd0, issue_ready}, 32'd1);
        check("hold_release_busy",  {31'd0, busy}, 32'd0);

        // MUL, latency 2
        cdb_grant = 1'b0;
        issue(4'h4, 3'd3, 16'h0100, 16'h0101);
        step;
        issue_valid = 1'b0;
        check("mul_req_early", {31'd0, cdb_req}, 32'd0);
        check("mul_busy", {31'd0, busy}, 32'd1);
        step;
        check("mul_req",  {31'd0, cdb_req}, 32'd1);
        check("mul_data", {16'd0, cdb_data}, 32'h0000_0100);
        check("mul_tag",  {29'd0, cdb_tag}, 32'd3);
        cdb_grant = 1'b1;
        step;
        check("mul_idle", {31'd0, busy}, 32'd0);

        // unsupported opcode, then a valid op clears the error
        cdb_grant = 1'b0;
        issue(4'hF, 3'd4, 16'd7, 16'd9);
        step;
        issue_valid = 1'b0;
        check("bad_req",  {31'd0, cdb_req}, 32'd1);
        check("bad_err",  {31'd0, cdb_err}, 32'd1);
        check("bad_data", {16'd0, cdb_data}, 32'd0);
        cdb_grant = 1'b1;
        step;
        issue(4'h0, 3'd5, 16'd1, 16'd2);
        step;
        issue_valid = 1'b0;
        check("clr_err",  {31'd0, cdb_err}, 32'd0);
        check("clr_data", {16'd0, cdb_data}, 32'd3);
        step;

        // flush during MUL execution
        cdb_grant = 1'b0;
        issue(4'h4, 3'd6, 16'd2, 16'd3);
        step;
        issue_valid = 1'b0;
        check("fl_exec_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_ready_low", {31'd0, issue_ready}, 32'd0);
        step;
        flush = 1'b0;
        check("fl_exec_req",  {31'd0, cdb_req}, 32'd0);
        check("fl_exec_busy2", {31'd0, busy}, 32'd0);
        step;
        check("fl_exec_late", {31'd0, cdb_req}, 32'd0);

        // flush beats a simultaneous grant and a simultaneous issue
        issue(4'h0, 3'd1, 16'd1, 16'd1);
        step;
        check("fg_req", {31'd0, cdb_req}, 32'd1);
        flush = 1'b1;
        cdb_grant = 1'b1;
        issue(4'h2, 3'd2, 16'hFFFF, 16'h00FF);
        step;
        flush = 1'b0;
        issue_valid = 1'b0;
        cdb_grant = 1'b0;
        check("fg_req_gone", {31'd0, cdb_req}, 32'd0);
        check("fg_not_acc",  {31'd0, busy}, 32'd0);
        step;
        check("fg_still_idle", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-EXEC
        issue(4'h4, 3'd7, 16'd4, 16'd4);
        step;
        issue_valid = 1'b0;
        check("ar_busy_pre", {31'd0, busy}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_req",  {31'd0, cdb_req}, 32'd0);
        check("ar_data", {16'd0, cdb_data}, 32'd0);
        check("ar_tag",  {29'd0, cdb_tag}, 32'd0);
        #2;
        reset_n = 1'b1;
        step;
        check("ar_after_req", {31'd0, cdb_req}, 32'd0);
        check("ar_after_ready", {31'd0, issue_ready}, 32'd1);

        // wide instance: MUL with latency 4
        w_valid = 1'b1; w_op = 4'h4; w_tag = 3'd5;
        w_a = 32'h0001_0001; w_b = 32'h0001_0000;
        step;
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w_req_early", {31'd0, w_req}, 32'd0);
            step;
        end
        check("w_req",  {31'd0, w_req}, 32'd1);
        check("w_data", w_data, 32'h0001_0000);
        check("w_tag",  {29'd0, w_cdb_tag}, 32'd5);
        w_grant = 1'b1;
        step;
        check("w_idle", {31'd0, w_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
